// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
//   Parametrised UART transmitter with valid/ready handshake. Frame format
//   is start bit, DATA_BITS data bits (LSB first), optional parity bit and
//   one or two stop bits. The clocks-per-bit divisor, parity mode and stop
//   count are sampled together with the payload when a frame is accepted.
//
//   Optional feature macro: UART_TX_BREAK_EN
//     When defined, adds i_Break. From IDLE a break holds the line low for
//     as long as i_Break stays high, then drives one bit time of idle-high
//     before the block becomes ready again.
//
// Parameters
//   DATA_BITS   data bits per frame (5..9)
//   CLK_DIV_W   width of the clocks-per-bit divisor
//
// Ports
//   i_Clock         system clock, rising edge
//   i_Rst_n         asynchronous active-low reset
//   i_Tx_Valid      frame request (payload and configuration valid)
//   o_Tx_Ready      block accepts a frame this cycle
//   i_Tx_Data       frame payload
//   i_Clks_Per_Bit  clocks per bit, 0 behaves as 1
//   i_Parity_Mode   00 none, 01 even, 10 odd, 11 none
//   i_Stop_Bits2    0: one stop bit, 1: two stop bits
//   i_Break         (UART_TX_BREAK_EN only) request a line break
//   o_Tx_Serial     registered serial line, idle high
//   o_Tx_Active     high from the first start-bit cycle to the last stop-bit cycle
//   o_Tx_Done       one-cycle pulse on the final cycle of a frame
//   o_Bit_Index     index of the data bit on the line, 0 outside the data bits
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int CLK_DIV_W = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Tx_Valid,
  output logic                 o_Tx_Ready,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  input  logic [CLK_DIV_W-1:0] i_Clks_Per_Bit,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Stop_Bits2,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_Break,
`endif
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done,
  output logic [3:0]           o_Bit_Index
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    , S_BREAK,
    S_BRK_REC
`endif
  } state_t;

  // The bit counter compares against N-1; a divisor of 0 collapses to 1 clk/bit.
  function automatic logic [CLK_DIV_W-1:0] div_to_last(input logic [CLK_DIV_W-1:0] div);
    return (div == '0) ? '0 : div - CLK_DIV_W'(1);
  endfunction

  state_t                 state_q, state_d;
  logic [CLK_DIV_W-1:0]   cnt_q, cnt_d;
  logic [CLK_DIV_W-1:0]   last_q, last_d;
  logic [3:0]             bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic                   par_en_q, par_en_d;
  logic                   stop2_q, stop2_d;
  logic                   serial_q, serial_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   bit_end;
  logic                   brk_req;

  assign bit_end = (cnt_q == last_q);

`ifdef UART_TX_BREAK_EN
  assign brk_req = i_Break;
`else
  assign brk_req = 1'b0;
`endif

  // ---- state register -----------------------------------------------------
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      serial_q <= serial_d;
    end
  end

  // Payload and parity are only read after an accept, so they carry no reset.
  always_ff @(posedge i_Clock) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  // ---- next-state logic ---------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;
    shift_d  = shift_q;
    par_d    = par_q;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        if (brk_req) begin
`ifdef UART_TX_BREAK_EN
          state_d = S_BREAK;
`endif
        end else if (i_Tx_Valid) begin
          state_d  = S_START;
          last_d   = div_to_last(i_Clks_Per_Bit);
          shift_d  = i_Tx_Data;
          par_en_d = (i_Parity_Mode == 2'b01) || (i_Parity_Mode == 2'b10);
          par_d    = (^i_Tx_Data) ^ (i_Parity_Mode == 2'b10);
          stop2_d  = i_Stop_Bits2;
        end
      end

      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CLK_DIV_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CLK_DIV_W'(1);
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CLK_DIV_W'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop2_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            stop_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CLK_DIV_W'(1);
        end
      end

`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        cnt_d = '0;
        // The recovery bit time uses whatever divisor is presented at release.
        if (!i_Break) begin
          state_d = S_BRK_REC;
          last_d  = div_to_last(i_Clks_Per_Bit);
        end
      end

      S_BRK_REC: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CLK_DIV_W'(1);
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        stop_d  = 1'b0;
      end
    endcase

    // The line is registered from the upcoming state so it changes on the
    // same edge as the state itself.
    case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = par_d;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  serial_d = 1'b0;
`endif
      default:  serial_d = 1'b1;
    endcase
  end

  // ---- outputs ------------------------------------------------------------
  always_comb begin
    o_Tx_Serial = serial_q;
    o_Tx_Ready  = (state_q == S_IDLE) && !brk_req && i_Rst_n;
    o_Tx_Active = (state_q == S_START) || (state_q == S_DATA) ||
                  (state_q == S_PARITY) || (state_q == S_STOP);
    o_Tx_Done   = (state_q == S_STOP) && bit_end && (!stop2_q || stop_q);
    o_Bit_Index = (state_q == S_DATA) ? bit_q : 4'd0;
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [7:0]  tx_data;
  logic [15:0] div;
  logic [1:0]  mode;
  logic        stop2;
  logic        brk;
  logic        serial;
  logic        active;
  logic        done;
  logic [3:0]  bit_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .CLK_DIV_W(16)) dut (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_Tx_Valid     (valid),
    .o_Tx_Ready     (ready),
    .i_Tx_Data      (tx_data),
    .i_Clks_Per_Bit (div),
    .i_Parity_Mode  (mode),
    .i_Stop_Bits2   (stop2),
`ifdef UART_TX_BREAK_EN
    .i_Break        (brk),
`endif
    .o_Tx_Serial    (serial),
    .o_Tx_Active    (active),
    .o_Tx_Done      (done),
    .o_Bit_Index    (bit_idx)
  );

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [1:0]  mode;
    logic        stop2;
    int          n_eff;
    logic [15:0] bits;   // line value of bit slot k at bit k (start = slot 0)
    int          len;    // frame length in clocks
  } vec_t;

  vec_t vec [9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Launches one frame from IDLE and checks every cycle of it. Inputs are
  // scrambled right after accept so any leak of live inputs shows up.
  task automatic run_frame(input vec_t v, input string tag);
    int line_err, idx_err, ctl_err, done_cnt, done_pos, slot, exp_idx;
    line_err = 0; idx_err = 0; ctl_err = 0; done_cnt = 0; done_pos = -1;
    tx_data = v.data; div = v.div; mode = v.mode; stop2 = v.stop2; valid = 1'b1;
    check({tag, "_ready"}, int'(ready), 1);
    @(posedge clk); #1;
    valid = 1'b0; tx_data = ~v.data; div = v.div + 16'd3; mode = ~v.mode; stop2 = ~v.stop2;
    for (int c = 0; c < v.len; c++) begin
      slot = c / v.n_eff;
      if (serial !== v.bits[slot]) line_err++;
      exp_idx = (slot >= 1 && slot <= 8) ? slot - 1 : 0;
      if (bit_idx !== 4'(exp_idx)) idx_err++;
      if (active !== 1'b1 || ready !== 1'b0) ctl_err++;
      if (done === 1'b1) begin done_cnt++; done_pos = c; end
      @(posedge clk); #1;
    end
    check({tag, "_line"}, line_err, 0);
    check({tag, "_idx"}, idx_err, 0);
    check({tag, "_ctl"}, ctl_err, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_pos"}, done_pos, v.len - 1);
    check({tag, "_idle"}, int'({serial, ready, active, done}), 4'b1100);
  endtask

  initial begin
    int err, dcnt;
    logic [15:0] f1, f2;
    logic exp_bit;

    //          data   div     mode   s2    N  bits      len
    vec[0] = '{8'hA5, 16'd4, 2'b00, 1'b0, 4, 16'h034A, 40};  // basic 8N1
    vec[1] = '{8'h07, 16'd2, 2'b01, 1'b0, 2, 16'h060E, 22};  // even parity -> 1
    vec[2] = '{8'h07, 16'd2, 2'b10, 1'b0, 2, 16'h040E, 22};  // odd parity -> 0
    vec[3] = '{8'h07, 16'd2, 2'b11, 1'b0, 2, 16'h020E, 20};  // mode 11 = none
    vec[4] = '{8'hA5, 16'd8, 2'b00, 1'b0, 8, 16'h034A, 80};  // new divisor takes effect
    vec[5] = '{8'h3C, 16'd0, 2'b00, 1'b0, 1, 16'h0278, 10};  // divisor 0 -> 1
    vec[6] = '{8'h55, 16'd3, 2'b00, 1'b1, 3, 16'h06AA, 33};  // two stop bits
    vec[7] = '{8'h80, 16'd1, 2'b10, 1'b1, 1, 16'h0D00, 12};  // odd parity, 2 stop
    vec[8] = '{8'hFF, 16'd1, 2'b01, 1'b0, 1, 16'h05FE, 11};  // even parity of 0xFF -> 0

    rst_n = 1'b0; valid = 1'b0; tx_data = 8'h00; div = 16'd4; mode = 2'b00;
    stop2 = 1'b0; brk = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", int'({serial, ready, active, done}), 4'b1000);
    check("rst_bit_idx", int'(bit_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", int'(ready), 1);

    for (int i = 0; i < 9; i++) begin
      run_frame(vec[i], $sformatf("vec%0d", i));
    end

    // Back-to-back with valid held high: 0x55 then 0xAA, N=3, two stop bits.
    f1 = 16'h06AA; f2 = 16'h0754;
    tx_data = 8'h55; div = 16'd3; mode = 2'b00; stop2 = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'hAA;
    err = 0; dcnt = 0;
    for (int c = 0; c < 67; c++) begin
      if (c < 33)       exp_bit = f1[c / 3];
      else if (c == 33) exp_bit = 1'b1;
      else              exp_bit = f2[(c - 34) / 3];
      if (serial !== exp_bit) err++;
      if (ready !== (c == 33)) err++;
      if (done !== (c == 32 || c == 66)) err++;
      if (done === 1'b1) dcnt++;
      if (c == 34) valid = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b_stream", err, 0);
    check("b2b_done_cnt", dcnt, 2);
    check("b2b_idle", int'({serial, ready, active}), 3'b110);

    // Reset during data bit 3 of a 0x00 frame.
    tx_data = 8'h00; div = 16'd4; mode = 2'b00; stop2 = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (17) begin @(posedge clk); #1; end
    check("rstmid_pre_line", int'(serial), 0);
    check("rstmid_pre_idx", int'(bit_idx), 3);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_async", int'({serial, ready, active, done}), 4'b1000);
    dcnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || serial !== 1'b1) dcnt++;
    end
    check("rstmid_held", dcnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid_ready", int'({serial, ready}), 2'b11);
    run_frame(vec[0], "after_rst");

`ifdef UART_TX_BREAK_EN
    // Break of 20 clocks with N=4: 20 low, 4 high, then ready.
    div = 16'd4; brk = 1'b1;
    err = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (serial !== 1'b0 || ready !== 1'b0 || active !== 1'b0) err++;
    end
    brk = 1'b0;
    check("brk_low", err, 0);
    err = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (serial !== 1'b1 || ready !== 1'b0) err++;
    end
    check("brk_recover", err, 0);
    @(posedge clk); #1;
    check("brk_ready", int'({serial, ready}), 2'b11);

    // Break raised mid-frame waits for the frame to finish.
    tx_data = 8'h00; div = 16'd1; mode = 2'b00; stop2 = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    err = 0; dcnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) brk = 1'b1;
      if (serial !== (c == 9)) err++;
      if (done !== (c == 9)) err++;
      if (done === 1'b1) dcnt++;
      @(posedge clk); #1;
    end
    check("brk_mid_frame", err, 0);
    check("brk_mid_done", dcnt, 1);
    check("brk_mid_idle", int'({serial, ready}), 2'b10);
    @(posedge clk); #1;
    check("brk_mid_low", int'(serial), 0);
    brk = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("brk_mid_end", int'({serial, ready}), 2'b11);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
